// File: rtl/bcd_pkg.sv
// Shared types and default sizing for the BCD-to-binary converter.
package bcd_pkg;

  localparam int BCD_DIGITS = 4;
  localparam int BCD_BIN_W  = 14;
  localparam int DIGIT_W    = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// Reverse double-dabble correction for one BCD digit: subtract 3 when the digit is 8 or more.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] d,
  output logic [DIGIT_W-1:0] q
);

  assign q = (d >= 4'd8) ? d - 4'd3 : d;

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter (reverse double-dabble, one bit per clock).
// Define BCD_TO_BIN_CHECK_EN to reject input words holding a digit above 9.
module bcd_to_bin
  import bcd_pkg::*;
#(
  parameter int DIGITS = BCD_DIGITS,
  parameter int BIN_W  = BCD_BIN_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [DIGIT_W*DIGITS-1:0] bcd,
  output logic [BIN_W-1:0]        bin,
  output logic                    rdy,
  output logic                    busy,
  output logic                    err
);

  localparam int BCD_W = DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);

  state_t            state;
  logic [BCD_W-1:0]  bcd_r;
  logic [BIN_W-1:0]  bin_r;
  logic [CNT_W-1:0]  cnt;

  logic [BCD_W-1:0]  bcd_sh;
  logic [BCD_W-1:0]  bcd_adj;
  logic [BIN_W-1:0]  bin_sh;

  // One-bit logical right shift across the whole {bcd_r, bin_r} register.
  assign bcd_sh = {1'b0, bcd_r[BCD_W-1:1]};
  assign bin_sh = {bcd_r[0], bin_r[BIN_W-1:1]};

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d (bcd_sh [g*DIGIT_W +: DIGIT_W]),
      .q (bcd_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

`ifdef BCD_TO_BIN_CHECK_EN
  logic bad;
  logic err_q;

  // NOTE: default assignment first so the loop below can never infer a latch.
  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[i*DIGIT_W +: DIGIT_W] > 4'd9) bad = 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // NOTE: all state is sequential, so only non-blocking assignments appear here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      bcd_r <= '0;
      bin_r <= '0;
      cnt   <= '0;
      bin   <= '0;
      rdy   <= 1'b0;
      busy  <= 1'b0;
`ifdef BCD_TO_BIN_CHECK_EN
      err_q <= 1'b0;
`endif
    end else begin
      rdy <= 1'b0;
      case (state)
        IDLE: begin
          if (en) begin
`ifdef BCD_TO_BIN_CHECK_EN
            if (bad) begin
              // Invalid word: report immediately and never enter SHIFT.
              bin   <= '0;
              err_q <= 1'b1;
              rdy   <= 1'b1;
            end else begin
              bcd_r <= bcd;
              bin_r <= '0;
              cnt   <= '0;
              busy  <= 1'b1;
              state <= SHIFT;
            end
`else
            bcd_r <= bcd;
            bin_r <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
`endif
          end
        end
        SHIFT: begin
          bcd_r <= bcd_adj;
          bin_r <= bin_sh;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            bin   <= bin_sh;
            rdy   <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
`ifdef BCD_TO_BIN_CHECK_EN
            err_q <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/bcd_to_bin.md
# bcd_to_bin

Sequential BCD-to-binary converter: the inverse of the binary-to-BCD converter feeding the seven-segment display path. It accepts a packed multi-digit BCD word (e.g. from digit-entry switches or a stored display value) and produces the equivalent unsigned binary count. It uses the reverse double-dabble algorithm: one right-shift per clock, followed by a per-digit subtract-3 correction. Results are presented with an `en`/`rdy` handshake that matches the existing converter's style.

## Interface
- `DIGITS`, default 4: number of BCD digits in the input word.
- `BIN_W`, default 14: binary result width. Must satisfy `2^BIN_W >= 10^DIGITS`. The default covers 0..9999.
- `clk`  in  1: single system clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `en`  in  1: start request, sampled on a rising `clk` edge while idle.
- `bcd`  in  4*DIGITS: packed BCD input, digit 0 in bits [3:0]. Sampled only on the accepting edge.
- `bin`  out  BIN_W: converted result. Holds its value until the next completion.
- `rdy`  out  1: one-cycle pulse, high in the cycle in which a new `bin` (and `err`) is first valid.
- `busy`  out  1: high while a conversion is in progress.
- `err`  out  1: invalid-digit flag, qualified by `rdy` (see Configuration).

## Operation
- Internal shift register: `{bcd_r[4*DIGITS-1:0], bin_r[BIN_W-1:0]}` plus an iteration counter `cnt` sized to hold 0..BIN_W.
- States:
  - IDLE: `busy=0`. If `en=1`, load `bcd_r<=bcd`, `bin_r<=0`, `cnt<=0`, and go to SHIFT.
  - SHIFT: `busy=1`. Each edge does the following:
    - Logically shift the concatenation right by 1.
    - Then, for every digit of the shifted `bcd_r` that is >= 8, subtract 3 from that digit.
    - Increment `cnt`.
    - On the edge where `cnt == BIN_W-1`: write `bin <= shifted bin_r`, set `rdy<=1`, and return to IDLE.
- `rdy` is cleared on the edge following its assertion.
- `en` is ignored while in SHIFT; no queuing and no restart.
- `en` held high continuously: a new conversion is accepted on the first IDLE edge after each `rdy`, i.e. back-to-back with one IDLE cycle between conversions.
- Arithmetic: digit correction is 4-bit, unsigned, with no carry between digits. After BIN_W iterations, `bcd_r` is 0 for valid input.
- `bin`, `err` and `rdy` change only at completion; `bin` is never partially updated.

## Timing
- Reset values: `bin=0`, `rdy=0`, `busy=0`, `err=0`, state IDLE, `cnt=0`, shift register 0.
- Latency: `en` accepted at edge k gives `rdy` high during the cycle after edge k+BIN_W (14 cycles at the defaults). `busy` is high from edge k+1 through edge k+BIN_W.
- Throughput: one conversion per BIN_W+1 cycles.
- Reset asserted mid-conversion: immediate return to the reset values. The aborted conversion produces no `rdy`.
- Reset released while `en=1`: the first accepting edge is the first clock edge with `rst=0`.

## Configuration
- `BCD_TO_BIN_CHECK_EN` defined:
  - On the accepting edge, any input digit > 9 causes a skip of SHIFT.
  - Next edge: `rdy=1`, `err=1`, `bin=0`.
  - Valid input converts normally with `err=0` at `rdy`.
- Not defined:
  - `err` is constant 0, with no check logic.
  - Invalid digits are converted through the normal path with the normal latency. `bin` is deterministic but unspecified, and the block never hangs.

## Structure
- Shared package `bcd_pkg`:
  - state enum (IDLE, SHIFT);
  - default constants `BCD_DIGITS=4` and `BCD_BIN_W=14`;
  - digit width constant 4.
- Sub-module `bcd_digit_adj`: combinational, one 4-bit digit in and one out, applying `d>=8 ? d-3 : d`. It is instantiated DIGITS times in a generate loop.
- FSM, counter, shift register and output registers live in `bcd_to_bin`.

## Test plan
- Reset, then `en` with `bcd=16'h0000` -> `rdy` 14 cycles after the accept edge with `bin=0`, `err=0`; `busy` high for exactly 14 cycles.
- `bcd=16'h9999` -> `bin=14'd9999` (`0x270F`). `bcd=16'h1234` -> `bin=14'd1234` (`0x4D2`). Sweep all 0000..9999 against a reference model.
- Pulse `en` again with `bcd=16'h0042` mid-conversion of `16'h0500` -> only one `rdy`, with `bin=500`. The second request is ignored.
- `en` held high with `bcd=16'h0001` -> `rdy` pulses every 15 cycles, each single-cycle, `bin=1`.
- Assert `rst` at cycle 7 of a `16'h8888` conversion -> all outputs 0 immediately. No `rdy` follows, and the next `en` with `16'h0007` yields `bin=7`.
- With `BCD_TO_BIN_CHECK_EN` defined, `bcd=16'h12A4` -> `rdy` with `err=1`, `bin=0` on the edge after accept. Without the macro, same stimulus -> `rdy` after 14 cycles with `err=0`.
